// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_ctrl
//  Purpose  : Board-I/O front end between raw DE0-CV pins and the core.
//             - 2-flop synchronisers on every button and switch input
//             - per-button debouncer with level output and one-cycle press pulse
//             - free-running tick every DIVISOR cycles, driving a blink phase
//             - NUM_HEX registered 7-segment digit drivers with blank/blink
//  Ports    : clk, rst (sync, active-high)
//             btn_raw[NUM_BTN]   async buttons, pressed = 1
//             sw_raw[NUM_SW]     async switches
//             value[4*NUM_HEX]   nibble i -> digit i
//             blank/blink[NUM_HEX]
//             tick, btn_level, btn_press, sw_sync, hex[7*NUM_HEX] {g..a}
//  Revision : 1.0  initial release
// ============================================================================
module board_io_ctrl #(
    parameter int DIVISOR        = 50_000_000,
    parameter int DEBOUNCE       = 500_000,
    parameter int NUM_BTN        = 3,
    parameter int NUM_SW         = 9,
    parameter int NUM_HEX        = 4,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BTN-1:0]     btn_raw,
    input  logic [NUM_SW-1:0]      sw_raw,
    input  logic [4*NUM_HEX-1:0]   value,
    input  logic [NUM_HEX-1:0]     blank,
    input  logic [NUM_HEX-1:0]     blink,
    output logic                   tick,
    output logic [NUM_BTN-1:0]     btn_level,
    output logic [NUM_BTN-1:0]     btn_press,
    output logic [NUM_SW-1:0]      sw_sync,
    output logic [7*NUM_HEX-1:0]   hex
);

    localparam int TW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int DBW = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0]  c_tick_max = TW'(DIVISOR - 1);
    localparam logic [DBW-1:0] c_db_last  = DBW'(DEBOUNCE - 1);
    localparam logic [6:0]     c_pol      = {7{HEX_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [NUM_SW-1:0]  r_sw_s1,  r_sw_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign sw_sync = r_sw_s2;

    // ------------------------------------------------------------------
    // Debouncers: the counter only advances while the synchronised input
    // disagrees with the accepted level, and toggles on the DEBOUNCE-th
    // consecutive disagreeing cycle, so it never exceeds DEBOUNCE-1.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_btn_level;
    logic [NUM_BTN-1:0] w_btn_press;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [DBW-1:0] r_cnt;
            logic           r_level;
            logic           r_press;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_press <= 1'b0;
                    if (r_btn_s2[gi] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_cnt   <= '0;
                        r_level <= ~r_level;
                        // Pulse only on the 0->1 acceptance, in the same
                        // cycle the new level becomes visible.
                        r_press <= ~r_level;
                    end else begin
                        r_cnt <= r_cnt + DBW'(1);
                    end
                end
            end

            assign w_btn_level[gi] = r_level;
            assign w_btn_press[gi] = r_press;
        end
    endgenerate

    assign btn_level = w_btn_level;
    assign btn_press = w_btn_press;

    // ------------------------------------------------------------------
    // Tick generator and blink phase. The tick is registered from the
    // next counter value so it lines up with the counter holding
    // DIVISOR-1 while staying low through reset (DIVISOR=1 -> stuck high).
    // ------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic [TW-1:0] w_tick_cnt_nxt;
    logic          r_tick;
    logic          r_phase;

    assign w_tick_cnt_nxt = (r_tick_cnt == c_tick_max) ? '0 : r_tick_cnt + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_phase    <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick     <= (w_tick_cnt_nxt == c_tick_max);
            r_phase    <= r_phase ^ r_tick;
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------
    // 7-segment drivers
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [7*NUM_HEX-1:0] w_hex;

    generate
        for (genvar gh = 0; gh < NUM_HEX; gh++) begin : g_hex
            logic       w_dark;
            logic [6:0] r_digit;

            assign w_dark = blank[gh] | (blink[gh] & r_phase);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_digit <= c_pol;
                end else if (w_dark) begin
                    r_digit <= c_pol;
                end else begin
                    r_digit <= seg_decode(value[4*gh +: 4]) ^ c_pol;
                end
            end

            assign w_hex[7*gh +: 7] = r_digit;
        end
    endgenerate

    assign hex = w_hex;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_io_ctrl
//  Purpose  : Self-checking bench for board_io_ctrl. Main instance uses
//             DIVISOR=4, DEBOUNCE=8, four active-low digits; a second
//             instance uses a single active-high digit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  btn_raw = '0;
    logic [8:0]  sw_raw  = '0;
    logic [15:0] value   = '0;
    logic [3:0]  blank   = '0;
    logic [3:0]  blink   = '0;
    logic        tick;
    logic [2:0]  btn_level;
    logic [2:0]  btn_press;
    logic [8:0]  sw_sync;
    logic [27:0] hex;

    logic        s_btn_raw = 1'b0;
    logic        s_sw_raw  = 1'b0;
    logic [3:0]  s_value   = '0;
    logic        s_blank   = 1'b0;
    logic        s_blink   = 1'b0;
    logic        s_tick;
    logic        s_btn_level;
    logic        s_btn_press;
    logic        s_sw_sync;
    logic [6:0]  s_hex;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    board_io_ctrl #(
        .DIVISOR(4), .DEBOUNCE(8), .NUM_BTN(3), .NUM_SW(9), .NUM_HEX(4), .HEX_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .value(value),
        .blank(blank), .blink(blink), .tick(tick), .btn_level(btn_level),
        .btn_press(btn_press), .sw_sync(sw_sync), .hex(hex)
    );

    board_io_ctrl #(
        .DIVISOR(4), .DEBOUNCE(8), .NUM_BTN(1), .NUM_SW(1), .NUM_HEX(1), .HEX_ACTIVE_LOW(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .btn_raw(s_btn_raw), .sw_raw(s_sw_raw), .value(s_value),
        .blank(s_blank), .blink(s_blink), .tick(s_tick), .btn_level(s_btn_level),
        .btn_press(s_btn_press), .sw_sync(s_sw_sync), .hex(s_hex)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 after the last reset edge, rst low.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    function automatic logic [27:0] hex_al(input logic [15:0] v, input logic [3:0] dark);
        logic [27:0] r;
        for (int d = 0; d < 4; d++)
            r[7*d +: 7] = dark[d] ? 7'h7F : ~seg_tab[v[4*d +: 4]];
        return r;
    endfunction

    task automatic test_reset();
        logic [63:0] e;
        btn_raw = 3'b111;
        sw_raw  = 9'h1FF;
        value   = 16'h0123;
        s_value = 4'h5;
        rst     = 1'b1;
        repeat (3) step();
        exp_q.push_back({35'd0, 1'b0, 3'b000, 3'b000, 9'h000, 7'h00, 28'hFFFFFFF});
        e = exp_q.pop_front();
        n_cmp++; if (tick !== e[44]) begin n_err++; $display("FAIL reset_tick: got %b want %b", tick, e[44]); end
        n_cmp++; if (btn_level !== e[43:41]) begin n_err++; $display("FAIL reset_level: got %b want %b", btn_level, e[43:41]); end
        n_cmp++; if (btn_press !== e[40:38]) begin n_err++; $display("FAIL reset_press: got %b want %b", btn_press, e[40:38]); end
        n_cmp++; if (sw_sync !== e[37:29]) begin n_err++; $display("FAIL reset_sw: got %h want %h", sw_sync, e[37:29]); end
        n_cmp++; if (hex !== e[27:0]) begin n_err++; $display("FAIL reset_hex: got %h want %h", hex, e[27:0]); end
        n_cmp++; if (s_hex !== e[34:28]) begin n_err++; $display("FAIL reset_hex_small: got %h want %h", s_hex, e[34:28]); end
        btn_raw = '0;
        sw_raw  = '0;
        rst     = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_tick();
        logic [63:0] e;
        do_reset(2);
        for (int n = 1; n <= 13; n++) exp_q.push_back({63'd0, (n % 4 == 0)});
        for (int n = 1; n <= 13; n++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (tick !== e[0]) begin n_err++; $display("FAIL tick_cycle%0d: got %b want %b", n, tick, e[0]); end
            step();
        end
    endtask

    task automatic test_sw();
        logic [8:0]  pat [6] = '{9'h1A5, 9'h05A, 9'h1FF, 9'h000, 9'h101, 9'h0F0};
        logic [8:0]  prev;
        logic [63:0] e;
        prev = sw_raw;
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            sw_raw = pat[i];
            exp_q.push_back({55'd0, prev});
            exp_q.push_back({55'd0, pat[i]});
            step();
            e = exp_q.pop_front();
            n_cmp++; if (sw_sync !== e[8:0]) begin n_err++; $display("FAIL sw_lat1_%0d: got %h want %h", i, sw_sync, e[8:0]); end
            step();
            e = exp_q.pop_front();
            n_cmp++; if (sw_sync !== e[8:0]) begin n_err++; $display("FAIL sw_lat2_%0d: got %h want %h", i, sw_sync, e[8:0]); end
            prev = pat[i];
        end
    endtask

    // Checks {press,level} for 12 edges after the stimulus change.
    task automatic check_btn_window(input string name, input logic [2:0] press_at10,
                                    input logic [2:0] lvl_before, input logic [2:0] lvl_after);
        logic [63:0] e;
        for (int k = 1; k <= 12; k++)
            exp_q.push_back({58'd0, (k == 10) ? press_at10 : 3'b000,
                             (k >= 10) ? lvl_after : lvl_before});
        for (int k = 1; k <= 12; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({btn_press, btn_level} !== e[5:0]) begin
                n_err++;
                $display("FAIL %s_k%0d: press/level got %b/%b want %b/%b",
                         name, k, btn_press, btn_level, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_debounce();
        btn_raw = '0;
        do_reset(2);
        for (int seg = 0; seg < 10; seg++) begin
            btn_raw[0] = (seg % 2 == 0);
            repeat (3) begin
                n_cmp++;
                if (btn_press !== 3'b000 || btn_level !== 3'b000) begin
                    n_err++;
                    $display("FAIL bounce_seg%0d: press/level got %b/%b want 000/000", seg, btn_press, btn_level);
                end
                step();
            end
        end
        btn_raw[0] = 1'b1;
        check_btn_window("press0", 3'b001, 3'b000, 3'b001);
        btn_raw[0] = 1'b0;
        check_btn_window("release0", 3'b000, 3'b001, 3'b000);
    endtask

    task automatic test_back_to_back();
        btn_raw = 3'b110;
        check_btn_window("press21", 3'b110, 3'b000, 3'b110);
        btn_raw = 3'b011;
        check_btn_window("swap", 3'b001, 3'b110, 3'b011);
        btn_raw = 3'b000;
        repeat (12) step();
    endtask

    task automatic test_hex();
        logic [63:0] e;
        logic [15:0] v;
        logic [3:0]  b;
        blink = '0;
        blank = '0;
        value = 16'h0123;
        exp_q.push_back({36'd0, 7'h40, 7'h79, 7'h24, 7'h30});
        step();
        e = exp_q.pop_front();
        n_cmp++; if (hex !== e[27:0]) begin n_err++; $display("FAIL hex_0123: got %h want %h", hex, e[27:0]); end
        for (int i = 0; i < 16; i++) begin
            v = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
            b = 4'($urandom_range(0, 15));
            value = v;
            blank = b;
            exp_q.push_back({36'd0, hex_al(v, b)});
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (hex !== e[27:0]) begin n_err++; $display("FAIL hex_val%0d: got %h want %h (value %h blank %b)", i, hex, e[27:0], v, b); end
        end
        blank = '0;
    endtask

    task automatic test_blink();
        logic [63:0] e;
        value = 16'h0123;
        blank = '0;
        blink = 4'b0010;
        do_reset(2);
        for (int n = 1; n <= 18; n++) begin
            if (n >= 2) begin
                exp_q.push_back({36'd0, 7'h40, 7'h79,
                                 ((((n - 2) / 4) % 2) == 1) ? 7'h7F : 7'h24, 7'h30});
                e = exp_q.pop_front();
                n_cmp++;
                if (hex !== e[27:0]) begin n_err++; $display("FAIL blink_cycle%0d: got %h want %h", n, hex, e[27:0]); end
            end
            step();
        end
        blink = '0;
    endtask

    task automatic test_reset_mid();
        btn_raw = '0;
        value   = 16'h0123;
        do_reset(2);
        btn_raw[0] = 1'b1;
        repeat (7) step();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            n_cmp++;
            if (hex !== 28'hFFFFFFF || tick !== 1'b0 || btn_level !== 3'b000 ||
                btn_press !== 3'b000 || sw_sync !== 9'h000) begin
                n_err++;
                $display("FAIL midrst_%0d: hex %h tick %b lvl %b press %b sw %h want FFFFFFF/0/000/000/000",
                         r, hex, tick, btn_level, btn_press, sw_sync);
            end
        end
        rst = 1'b0;
        check_btn_window("midrst", 3'b001, 3'b000, 3'b001);
        btn_raw = '0;
        repeat (12) step();
    endtask

    task automatic test_small();
        logic [63:0] e;
        logic [3:0]  v   [4] = '{4'hF, 4'hF, 4'h0, 4'h8};
        logic        bl  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            s_value = v[i];
            s_blank = bl[i];
            exp_q.push_back({57'd0, bl[i] ? 7'h00 : seg_tab[v[i]]});
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (s_hex !== e[6:0]) begin n_err++; $display("FAIL small_hex%0d: got %h want %h", i, s_hex, e[6:0]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick();
        test_sw();
        test_debounce();
        test_back_to_back();
        test_hex();
        test_blink();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
